uart_cmd_bridge: RTL and testbench

Serial front end of the copter command path. Receives 3-byte command frames (cmd, data high, data low) over an 8N1 UART line and presents them to `cmd_cfg` as `cmd`/`data` with a `cmd_rdy`/`clr_cmd_rdy` handshake. Serialises the single-byte `resp` from `cmd_cfg` back onto the line and signals completion with `resp_sent`. Sits between the RX/TX pins and `cmd_cfg`; the far end of the link is `CommMaster`.

---
 rtl/uart_cmd_bridge_if.sv | 31 +++
 rtl/uart_cmd_bridge.sv | 218 +++++++++++++++++++++
 tb/tb_uart_cmd_bridge.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_cmd_bridge_if.sv
// Command/response handshake bundle between the UART bridge and its consumer,
// plus read-only views of the bridge's FSM states.
interface uart_cmd_bridge_if;
  logic [7:0]  cmd;
  logic [15:0] data;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic [7:0]  resp;
  logic        snd_resp;
  logic        resp_sent;
  logic        frm_err;
  logic        rx_state_dbg;
  logic [1:0]  frm_state_dbg;
  logic        tx_state_dbg;

  // Handshakes: cmd_rdy rises with cmd/data already valid and holds them until
  // the consumer pulses clr_cmd_rdy (a completing frame beats a same-cycle clear);
  // snd_resp is a one-cycle request taken only while the transmitter is idle,
  // and resp_sent is a one-cycle pulse once the stop bit has been fully sent.
  modport master (
    output cmd, data, cmd_rdy, resp_sent, frm_err,
    output rx_state_dbg, frm_state_dbg, tx_state_dbg,
    input  clr_cmd_rdy, resp, snd_resp
  );

  modport slave (
    input  cmd, data, cmd_rdy, resp_sent, frm_err,
    input  rx_state_dbg, frm_state_dbg, tx_state_dbg,
    output clr_cmd_rdy, resp, snd_resp
  );
endinterface

// File: rtl/uart_cmd_bridge.sv
// 8N1 UART front end: assembles 3-byte command frames from RX and serialises
// one-byte responses onto TX. Receive and transmit paths run independently.
module uart_cmd_bridge #(
  parameter int BAUD_DIV = 2604,
  parameter int IDLE_TO  = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic RX,
  output logic TX,
  uart_cmd_bridge_if.master bus
);

  localparam int BW     = $clog2(BAUD_DIV);
  localparam int TO_MAX = IDLE_TO * BAUD_DIV;
  localparam int TW     = $clog2(TO_MAX + 1);
  localparam logic [BW-1:0] HALF_M1 = BW'(BAUD_DIV / 2 - 1);
  localparam logic [BW-1:0] FULL_M1 = BW'(BAUD_DIV - 1);
  localparam logic [TW-1:0] TO_M1   = TW'(TO_MAX - 1);

  typedef enum logic       {RX_IDLE, RX_BUSY} rx_state_t;
  typedef enum logic [1:0] {WAIT_CMD, WAIT_DH, WAIT_DL} frm_state_t;
  typedef enum logic       {TX_IDLE, TX_BUSY} tx_state_t;

  rx_state_t  rx_q, rx_d;
  frm_state_t frm_q, frm_d;
  tx_state_t  tx_q, tx_d;

  // ---------------- receive bit engine ----------------
  logic          rx_s1, rx_s2, rx_prev;
  logic [BW-1:0] rx_baud;
  logic [3:0]    rx_bit;
  logic [7:0]    rx_shift;
  logic          start_det, rx_tick, byte_vld, stop_err;

  // rx_prev gives a true falling edge, so a line still low after a bad stop
  // bit cannot start a phantom byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= RX;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  assign start_det = (rx_q == RX_IDLE) && rx_prev && !rx_s2;
  assign rx_tick   = (rx_q == RX_BUSY) &&
                     (rx_baud == ((rx_bit == 4'd0) ? HALF_M1 : FULL_M1));

  always_ff @(posedge clk) begin
    if (rst) rx_q <= RX_IDLE;
    else     rx_q <= rx_d;
  end

  always_comb begin
    rx_d = rx_q;
    case (rx_q)
      RX_IDLE: if (start_det) rx_d = RX_BUSY;
      RX_BUSY: if (rx_tick && ((rx_bit == 4'd0 && rx_s2) || rx_bit == 4'd9))
                 rx_d = RX_IDLE;
      default: rx_d = RX_IDLE;
    endcase
  end

  always_comb begin
    byte_vld = 1'b0;
    stop_err = 1'b0;
    if (rx_tick && rx_bit == 4'd9) begin
      byte_vld = rx_s2;
      stop_err = !rx_s2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_baud  <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else if (rx_q == RX_IDLE) begin
      rx_baud <= '0;
      rx_bit  <= '0;
    end else if (rx_tick) begin
      rx_baud <= '0;
      rx_bit  <= rx_bit + 4'd1;
      if (rx_bit != 4'd0 && rx_bit != 4'd9)
        rx_shift <= {rx_s2, rx_shift[7:1]};
    end else begin
      rx_baud <= rx_baud + BW'(1);
    end
  end

  // ---------------- frame assembler ----------------
  logic [7:0]    sh_cmd, sh_dh;
  logic [TW-1:0] to_cnt;
  logic          timeout, ld_cmd_sh, ld_dh_sh, frame_done;

  assign timeout = (frm_q != WAIT_CMD) && (rx_q == RX_IDLE) && !start_det &&
                   (to_cnt == TO_M1);

  always_ff @(posedge clk) begin
    if (rst) frm_q <= WAIT_CMD;
    else     frm_q <= frm_d;
  end

  always_comb begin
    frm_d = frm_q;
    if (stop_err || timeout) begin
      frm_d = WAIT_CMD;
    end else if (byte_vld) begin
      case (frm_q)
        WAIT_CMD: frm_d = WAIT_DH;
        WAIT_DH:  frm_d = WAIT_DL;
        default:  frm_d = WAIT_CMD;
      endcase
    end
  end

  always_comb begin
    ld_cmd_sh  = 1'b0;
    ld_dh_sh   = 1'b0;
    frame_done = 1'b0;
    if (byte_vld) begin
      case (frm_q)
        WAIT_CMD: ld_cmd_sh  = 1'b1;
        WAIT_DH:  ld_dh_sh   = 1'b1;
        default:  frame_done = 1'b1;
      endcase
    end
  end

  // The idle timer only runs while a frame is partial and the line is quiet.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_cmd      <= '0;
      sh_dh       <= '0;
      bus.cmd     <= '0;
      bus.data    <= '0;
      bus.cmd_rdy <= 1'b0;
      bus.frm_err <= 1'b0;
      to_cnt      <= '0;
    end else begin
      bus.frm_err <= stop_err || timeout;
      if (ld_cmd_sh) sh_cmd <= rx_shift;
      if (ld_dh_sh)  sh_dh  <= rx_shift;
      if (frame_done) begin
        bus.cmd  <= sh_cmd;
        bus.data <= {sh_dh, rx_shift};
      end
      if (frame_done)           bus.cmd_rdy <= 1'b1;
      else if (bus.clr_cmd_rdy) bus.cmd_rdy <= 1'b0;
      if (frm_q == WAIT_CMD || rx_q != RX_IDLE || start_det) to_cnt <= '0;
      else if (to_cnt != TO_M1)                              to_cnt <= to_cnt + TW'(1);
    end
  end

  // ---------------- transmitter ----------------
  logic [9:0]    tx_sh;
  logic [BW-1:0] tx_baud;
  logic [3:0]    tx_bit;
  logic          tx_tick, tx_go, tx_last;

  assign tx_tick = (tx_q == TX_BUSY) && (tx_baud == FULL_M1);
  assign tx_go   = (tx_q == TX_IDLE) && bus.snd_resp;
  assign tx_last = tx_tick && (tx_bit == 4'd9);

  always_ff @(posedge clk) begin
    if (rst) tx_q <= TX_IDLE;
    else     tx_q <= tx_d;
  end

  always_comb begin
    tx_d = tx_q;
    case (tx_q)
      TX_IDLE: if (tx_go)   tx_d = TX_BUSY;
      TX_BUSY: if (tx_last) tx_d = TX_IDLE;
      default: tx_d = TX_IDLE;
    endcase
  end

  // Idle shift register holds all ones, so TX is simply its LSB.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_sh         <= '1;
      tx_baud       <= '0;
      tx_bit        <= '0;
      bus.resp_sent <= 1'b0;
    end else begin
      bus.resp_sent <= tx_last;
      if (tx_go) begin
        tx_sh   <= {1'b1, bus.resp, 1'b0};
        tx_baud <= '0;
        tx_bit  <= '0;
      end else if (tx_tick) begin
        tx_baud <= '0;
        if (tx_last) begin
          tx_sh  <= '1;
          tx_bit <= '0;
        end else begin
          tx_sh  <= {1'b1, tx_sh[9:1]};
          tx_bit <= tx_bit + 4'd1;
        end
      end else if (tx_q == TX_BUSY) begin
        tx_baud <= tx_baud + BW'(1);
      end
    end
  end

  assign TX = tx_sh[0];

  assign bus.rx_state_dbg  = rx_q;
  assign bus.frm_state_dbg = frm_q;
  assign bus.tx_state_dbg  = tx_q;

endmodule

// File: tb/tb_uart_cmd_bridge.sv
// Bench for uart_cmd_bridge: directed frames/responses plus randomized full-duplex
// traffic, all checked each cycle against a byte/frame level model.
module tb_uart_cmd_bridge;
  localparam int B      = 16;
  localparam int HALF   = B / 2;
  localparam int ITO    = 32;
  localparam int TO_MAX = ITO * B;
  // Start edge -> 2 sync flops + edge flop, half bit, 9 more bits, then 1 cycle.
  localparam int LAT    = 3 + HALF + 9 * B;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;
  logic tx;

  uart_cmd_bridge_if bus();

  uart_cmd_bridge #(.BAUD_DIV(B), .IDLE_TO(ITO)) dut (
    .clk(clk), .rst(rst), .RX(rx), .TX(tx), .bus(bus)
  );

  // ---------------- clock / cycle count ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [40:0] exp_q[$];   // {stop_ok, byte, cycle the byte takes effect}
  logic [7:0]  part[$];
  logic [7:0]  m_cmd = '0;
  logic [15:0] m_data = '0;
  logic        m_rdy = 1'b0, m_err, m_sent, m_tx;
  int          last_vis = -100000, last_edge = 0;
  bit          tx_act = 0;
  int          tx_c = 0;
  logic [9:0]  tx_frame;
  bit          clr_prev = 0, rst_prev = 1, chk_en = 0, rand_en = 0;
  logic [40:0] ev;
  logic        rdy_q = 1'b0;
  int          rdy_rise = 0, err_n = 0, err_cyc = 0, sent_n = 0, sent_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- reference model + per-cycle compare ----------------
  always @(negedge clk) begin
    m_err  = 1'b0;
    m_sent = 1'b0;
    if (rst_prev) begin
      m_cmd = '0; m_data = '0; m_rdy = 1'b0;
      part.delete(); exp_q.delete(); tx_act = 0;
    end else begin
      if (clr_prev) m_rdy = 1'b0;
      while (exp_q.size() > 0 && exp_q[0][31:0] == 32'(cyc)) begin
        ev = exp_q.pop_front();
        if (ev[40]) begin
          part.push_back(ev[39:32]);
          last_vis = cyc;
          if (part.size() == 3) begin
            m_cmd  = part[0];
            m_data = {part[1], part[2]};
            m_rdy  = 1'b1;
            part.delete();
          end
        end else begin
          m_err = 1'b1;
          part.delete();
        end
      end
      if (part.size() > 0 && cyc == last_vis + TO_MAX && last_edge <= last_vis) begin
        m_err = 1'b1;
        part.delete();
      end
      m_sent = tx_act && (cyc == tx_c + 10 * B + 1);
    end
    if (tx_act && cyc >= tx_c + 1 && cyc <= tx_c + 10 * B)
      m_tx = tx_frame[(cyc - tx_c - 1) / B];
    else
      m_tx = 1'b1;

    if (chk_en) begin
      check("TX", tx, m_tx);
      check("cmd", bus.cmd, m_cmd);
      check("data", bus.data, m_data);
      check("cmd_rdy", bus.cmd_rdy, m_rdy);
      check("frm_err", bus.frm_err, m_err);
      check("resp_sent", bus.resp_sent, m_sent);
    end

    if (bus.cmd_rdy && !rdy_q) rdy_rise = cyc;
    rdy_q = bus.cmd_rdy;
    if (bus.frm_err)   begin err_n++;  err_cyc  = cyc; end
    if (bus.resp_sent) begin sent_n++; sent_cyc = cyc; end

    rst_prev = rst;
    clr_prev = bus.clr_cmd_rdy;
    if (!rst && bus.snd_resp && (!tx_act || cyc > tx_c + 10 * B)) begin
      tx_act   = 1;
      tx_c     = cyc;
      tx_frame = {1'b1, bus.resp, 1'b0};
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    bus.snd_resp    = 1'b0;
    bus.clr_cmd_rdy = 1'b0;
    if (rand_en) begin
      if ($urandom_range(0, 63) == 0) begin
        bus.resp     = 8'($urandom_range(0, 255));
        bus.snd_resp = 1'b1;
      end
      if ($urandom_range(0, 99) == 0) bus.clr_cmd_rdy = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) tick();
  endtask

  // clr_k / abort_k: cycle offset within the byte for a clear pulse / a reset (-1 = none)
  task automatic send_byte(input logic [7:0] v, input bit stop_ok, input int clr_k,
                           input int abort_k, output int edge_c);
    logic [9:0] fr;
    fr = {stop_ok, v, 1'b0};
    edge_c = 0;
    for (int k = 0; k < 10 * B; k++) begin
      if (k == abort_k) begin
        rst = 1'b1;
        rx  = 1'b1;
        tick();
        rst = 1'b0;
        return;
      end
      if (k % B == 0) rx = fr[k / B];
      if (k == 0) begin
        edge_c    = cyc;
        last_edge = cyc;
        exp_q.push_back({stop_ok, v, 32'(cyc + LAT)});
      end
      if (k == clr_k) bus.clr_cmd_rdy = 1'b1;
      tick();
    end
    rx = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] dh,
                            input logic [7:0] dl, output int e3);
    int e;
    send_byte(c, 1'b1, -1, -1, e);
    send_byte(dh, 1'b1, -1, -1, e);
    send_byte(dl, 1'b1, -1, -1, e3);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int e, c0, err0, sent0;
    logic [9:0] got;
    bus.clr_cmd_rdy = 1'b0;
    bus.snd_resp    = 1'b0;
    bus.resp        = '0;
    repeat (4) tick();
    chk_en = 1;
    rst = 1'b0;
    tick();
    check("rst_TX", tx, 1'b1);
    check("rst_cmd", bus.cmd, 8'h00);
    check("rst_data", bus.data, 16'h0000);
    check("rst_cmd_rdy", bus.cmd_rdy, 1'b0);
    idle(2 * B);

    // basic frame, latency, clear
    send_frame(8'h02, 8'h00, 8'h06, e);
    check("rdy_latency", rdy_rise - e, 155);
    check("t1_cmd", bus.cmd, 8'h02);
    check("t1_data", bus.data, 16'h0006);
    check("t1_rdy", bus.cmd_rdy, 1'b1);
    bus.clr_cmd_rdy = 1'b1;
    tick();
    check("t1_clr_rdy", bus.cmd_rdy, 1'b0);
    check("t1_hold_cmd", bus.cmd, 8'h02);
    check("t1_hold_data", bus.data, 16'h0006);

    // response A5 with an ignored second strobe mid-frame
    sent0 = sent_n;
    bus.resp = 8'hA5;
    bus.snd_resp = 1'b1;
    c0 = cyc;
    for (int i = 0; i < 10; i++) begin
      while (cyc < c0 + 1 + i * B + HALF) tick();
      got[i] = tx;
      if (i == 4) begin
        bus.resp = 8'hFF;
        bus.snd_resp = 1'b1;
      end
    end
    while (cyc < c0 + 10 * B + 8) tick();
    check("t2_tx_bits", got, 10'b1101001010);
    check("t2_sent_lat", sent_cyc - c0, 161);
    check("t2_sent_cnt", sent_n - sent0, 1);

    // inter-byte timeout
    err0 = err_n;
    send_byte(8'h05, 1'b1, -1, -1, e);
    idle(40 * B);
    check("t3_err_cnt", err_n - err0, 1);
    check("t3_err_lat", err_cyc - e, 155 + 512);
    check("t3_rdy", bus.cmd_rdy, 1'b0);
    send_frame(8'h01, 8'h00, 8'h21, e);
    check("t3_cmd", bus.cmd, 8'h01);
    check("t3_data", bus.data, 16'h0021);
    bus.clr_cmd_rdy = 1'b1;
    tick();

    // bad stop bit on byte 2; the orphan third byte then times out
    err0 = err_n;
    send_byte(8'h03, 1'b1, -1, -1, e);
    send_byte(8'h00, 1'b0, -1, -1, e);
    idle(B);
    check("t4_rdy", bus.cmd_rdy, 1'b0);
    send_byte(8'h04, 1'b1, -1, -1, e);
    idle(40 * B);
    check("t4_err_cnt", err_n - err0, 2);
    send_frame(8'h04, 8'h00, 8'h02, e);
    check("t4_cmd", bus.cmd, 8'h04);
    check("t4_data", bus.data, 16'h0002);

    // clear on the completion cycle: set wins
    send_byte(8'h05, 1'b1, -1, -1, e);
    send_byte(8'h00, 1'b1, -1, -1, e);
    send_byte(8'h08, 1'b1, LAT - 1, -1, e);
    check("t5_rdy", bus.cmd_rdy, 1'b1);
    check("t5_cmd", bus.cmd, 8'h05);
    check("t5_data", bus.data, 16'h0008);

    // reset in the middle of byte 2 and of a response
    send_byte(8'h07, 1'b1, -1, -1, e);
    bus.resp = 8'h3C;
    bus.snd_resp = 1'b1;
    send_byte(8'h00, 1'b1, -1, 5 * B, e);
    check("t6_TX", tx, 1'b1);
    check("t6_cmd", bus.cmd, 8'h00);
    check("t6_data", bus.data, 16'h0000);
    check("t6_rdy", bus.cmd_rdy, 1'b0);
    check("t6_sent", bus.resp_sent, 1'b0);
    check("t6_err", bus.frm_err, 1'b0);
    idle(2 * B);
    send_frame(8'h08, 8'h00, 8'h00, e);
    check("t6_cmd2", bus.cmd, 8'h08);
    check("t6_rdy2", bus.cmd_rdy, 1'b1);

    // short low glitch: rejected by the start-bit recheck
    err0 = err_n;
    rx = 1'b0;
    repeat (3) tick();
    idle(3 * B);
    check("glitch_err", err_n - err0, 0);

    // randomized full-duplex traffic
    rand_en = 1;
    for (int f = 0; f < 16; f++) begin
      for (int b = 0; b < 3; b++) begin
        bit ok;
        ok = ($urandom_range(0, 9) != 0);
        send_byte(8'($urandom_range(0, 255)), ok, -1, -1, e);
        idle(ok ? $urandom_range(0, 5 * B) : $urandom_range(B, 5 * B));
      end
    end
    rand_en = 0;
    idle(TO_MAX + 12 * B);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
